// File: rtl/sort4_ctrl.sv
// -----------------------------------------------------------------------------
// sort4_ctrl
//   Sorts four unsigned WIDTH-bit elements into ascending order (e0 smallest)
//   with a single shared magnitude comparator. A fixed six-step bubble schedule
//   of pairs (0,1),(1,2),(2,3),(0,1),(1,2),(0,1) runs one step per cycle. Swaps
//   happen only on a strict a>b, so equal elements keep their order.
//
//   Timing: start is sampled in IDLE (load edge). The next six cycles are SORT,
//   one step each. The edge ending step 5 enters DONE and loads dout with the
//   post-step-5 elements. DONE lasts one cycle and then returns to IDLE, which
//   gives a minimum start-to-start period of 8 cycles.
//
// Handshake: start is a level request sampled only in IDLE; it is ignored in
//   SORT and DONE (no queuing). done pulses for exactly one cycle when dout is
//   freshly valid, and dout holds until the next DONE entry. busy is high for
//   the whole SORT phase.
//
// Ports
//   clk      in   clock, rising edge
//   rst      in   asynchronous, active-high reset
//   start    in   sort request (sampled in IDLE only)
//   din      in   4*WIDTH  elements e0..e3, ei = din[WIDTH*i +: WIDTH]
//   dout     out  4*WIDTH  sorted result, same packing, e0 smallest
//   busy     out  high while in SORT
//   done     out  one-cycle pulse in DONE
//   swap_cnt out  3 bits, swaps done by the last completed sort
//                 (present only when SORT4_SWAPCNT_EN is defined)
//
// Configuration macro: SORT4_SWAPCNT_EN
// -----------------------------------------------------------------------------
module sort4_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [4*WIDTH-1:0] din,
    output logic [4*WIDTH-1:0] dout,
    output logic               busy,
`ifdef SORT4_SWAPCNT_EN
    output logic               done,
    output logic [2:0]         swap_cnt
`else
    output logic               done
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SORT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Packed so that elem[i] lines up with din[WIDTH*i +: WIDTH].
    logic [3:0][WIDTH-1:0] elem, elem_nxt;
    logic [2:0]            step;
    logic [1:0]            idx_a, idx_b;
    logic [WIDTH-1:0]      op_a, op_b;
    logic                  swap;

    // Pair schedule: idx_a is always the lower-indexed element.
    always_comb begin
        idx_a = 2'd0;
        idx_b = 2'd1;
        case (step)
            3'd1, 3'd4: begin idx_a = 2'd1; idx_b = 2'd2; end
            3'd2:       begin idx_a = 2'd2; idx_b = 2'd3; end
            default:    begin idx_a = 2'd0; idx_b = 2'd1; end
        endcase
    end

    // The one comparator; strict greater-than keeps the sort stable.
    always_comb begin
        op_a     = elem[idx_a];
        op_b     = elem[idx_b];
        swap     = (state == SORT) && (op_a > op_b);
        elem_nxt = elem;
        if (swap) begin
            elem_nxt[idx_a] = op_b;
            elem_nxt[idx_b] = op_a;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = SORT;
            SORT: begin
                busy = 1'b1;
                if (step == 3'd5) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            elem <= '0;
            step <= 3'd0;
            dout <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    elem <= din;
                    step <= 3'd0;
                end
                SORT: begin
                    elem <= elem_nxt;
                    step <= step + 3'd1;
                    // Last step: publish the result including this step's swap.
                    if (step == 3'd5) dout <= elem_nxt;
                end
                default: ;
            endcase
        end
    end

`ifdef SORT4_SWAPCNT_EN
    logic [2:0] swap_acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            swap_acc <= 3'd0;
            swap_cnt <= 3'd0;
        end else begin
            case (state)
                IDLE: if (start) swap_acc <= 3'd0;
                SORT: begin
                    swap_acc <= swap_acc + {2'b00, swap};
                    if (step == 3'd5) swap_cnt <= swap_acc + {2'b00, swap};
                end
                default: ;
            endcase
        end
    end
`endif

endmodule
